jtdd_timing_gen: RTL

- Parametrised video timing generator for the jtdd cores. Successor to the fixed 384×(8..255) line/frame timer.
- Produces pixel/line counters, blanking, sync, bus-phase strobes, field parity and a frame-start strobe, all advanced by pxl_cen.
- Adds generics for line/frame geometry and sync placement, a runtime horizontal sync offset for screen centring, and an interlace-style field flag.
- Feeds the tilemap/object engines (HPOS/VPOS/M) and the video output stage (HBL/VBL/HS/VS).

---
 rtl/jtdd_timing_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jtdd_timing_gen.sv
// Parametrised video timing generator for the jtdd cores: pixel/line counters,
// blanking, sync, bus-phase strobes, field parity and frame start, advanced by pxl_cen.
module jtdd_timing_gen #(
  parameter int HW       = 9,
  parameter int VW       = 8,
  parameter int HTOTAL   = 384,
  parameter int HB_START = 256,
  parameter int HS_START = 309,
  parameter int HS_LEN   = 27,
  parameter int VSTART   = 8,
  parameter int VEND     = 255,
  parameter int VB_START = 248,
  parameter int VB_END   = 16,
  parameter int VBDLY    = 5,
  parameter int VS_START = 233,
  parameter int VS_LEN   = 3,
  parameter int MW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic [3:0]    hoff,
  output logic [7:0]    HPOS,
  output logic [VW-1:0] VPOS,
  output logic          HBL,
  output logic          VBL,
  output logic          HS,
  output logic          VS,
  output logic [MW-1:0] M,
  output logic          field,
  output logic          frame_start
);

  // VS falls VS_LEN lines after it rises, counted through the VEND->VSTART wrap
  localparam int VLINES = VEND - VSTART + 1;
  localparam int VS_END = (VS_START + VS_LEN > VEND) ? VS_START + VS_LEN - VLINES
                                                      : VS_START + VS_LEN;

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_BLANK  = HW'(HB_START);
  localparam logic [HW:0]   HS_BASE  = (HW+1)'(HS_START);
  localparam logic [HW:0]   HS_WIDTH = (HW+1)'(HS_LEN);
  localparam logic [VW-1:0] V_FIRST  = VW'(VSTART);
  localparam logic [VW-1:0] V_LAST   = VW'(VEND);
  localparam logic [VW-1:0] VB_ON    = VW'(VB_START);
  localparam logic [VW-1:0] VB_OFF   = VW'(VB_END);
  localparam logic [VW-1:0] VS_ON    = VW'(VS_START);
  localparam logic [VW-1:0] VS_OFF   = VW'(VS_END);

  logic [HW-1:0]    hn;
  logic [HW-1:0]    nextn;
  logic [VW-1:0]    vn;
  logic [VW-1:0]    vn_nx;
  logic [3:0]       hoff_l;
  logic [VBDLY-1:0] vbl_dly;
  logic [HW:0]      hs0;
  logic [HW:0]      hs1;
  logic             line_end;
  logic             frame_end;
  logic             raw_nx;
  logic             hs_rise;
  logic [MW-1:0]    m_nx;

  always_comb begin
    line_end  = (hn == H_LAST);
    nextn     = line_end ? '0 : hn + HW'(1);
    frame_end = line_end && (vn == V_LAST);
    vn_nx     = frame_end ? V_FIRST : vn + VW'(1);
    // vn always lies in VSTART..VEND, so the two raw-blank ranges reduce to these bounds
    raw_nx    = (vn_nx >= VB_ON) || (vn_nx < VB_OFF);
    hs0       = HS_BASE + {{(HW-3){hoff_l[3]}}, hoff_l};
    hs1       = hs0 + HS_WIDTH;
    hs_rise   = ({1'b0, nextn} == hs0);
    m_nx      = '0;
    for (int i = 0; i < MW; i++) begin
      m_nx[i] = nextn[0] && (nextn[3:1] == 3'(i));
    end
  end

  assign HPOS = hn[7:0] ^ {8{flip}};
  assign VBL  = vbl_dly[VBDLY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VPOS <= '0;
    end else begin
      VPOS <= vn ^ {VW{flip}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hn          <= '0;
      vn          <= V_FIRST;
      hoff_l      <= '0;
      vbl_dly     <= '0;
      HBL         <= 1'b0;
      HS          <= 1'b0;
      VS          <= 1'b0;
      M           <= '0;
      field       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pxl_cen) begin
        hn  <= nextn;
        HBL <= (nextn >= H_BLANK);
        HS  <= ({1'b0, nextn} >= hs0) && ({1'b0, nextn} < hs1);
        M   <= m_nx;
        // VS edges are tied to the HS leading edge so they follow hoff
        if (hs_rise) begin
          if (vn == VS_ON) begin
            VS <= 1'b1;
          end else if (vn == VS_OFF) begin
            VS <= 1'b0;
          end
        end
        if (line_end) begin
          vn         <= vn_nx;
          vbl_dly[0] <= raw_nx;
          for (int i = 1; i < VBDLY; i++) begin
            vbl_dly[i] <= vbl_dly[i-1];
          end
          if (frame_end) begin
            field       <= ~field;
            frame_start <= 1'b1;
            hoff_l      <= hoff;
          end
        end
      end
    end
  end

endmodule
